cpm_sweep_ctrl: RTL and testbench

Measurement sequencer for the programmable critical-path replica (CPL). It drives the four path-length selects, launches transitions into the replica input, and compares the registered replica output against the expected level. It sweeps path lengths from shortest to longest and reports how many consecutive lengths met timing. It sits between the scan/config logic and the CPL instance, one sequencer per CPL.

---
 rtl/cpm_pkg.sv | 32 +++
 rtl/cpm_launch_cap.sv | 57 +++++
 rtl/cpm_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_cpm_sweep_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpm_pkg.sv
// Shared definitions for the critical-path replica sweep sequencer.
//   cpm_state_e : sequencer state encoding
//   therm()     : path length (1..NUM_LEN) to thermometer-coded select word
//   NUM_LEN     : number of selectable replica path lengths
//   CODE_W      : width of the result code (holds 0..NUM_LEN)
package cpm_pkg;

   localparam int NUM_LEN = 4;
   localparam int CODE_W  = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_EVAL,
      ST_REPORT
   } cpm_state_e;

   function automatic logic [3:0] therm(input logic [CODE_W-1:0] len);
      logic [3:0] sel;
      case (len)
         3'd1:    sel = 4'b0001;
         3'd2:    sel = 4'b0011;
         3'd3:    sel = 4'b0111;
         3'd4:    sel = 4'b1111;
         default: sel = 4'b0000;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/cpm_launch_cap.sv
// Launch/capture datapath for one replica measurement.
//   clk, rst   : clock, synchronous active-high reset
//   fire       : toggle the launch pin this edge and arm the capture delay
//   in_wait    : sequencer is waiting for the replica output
//   clr_fail   : clear the fail counter (new path length)
//   capt       : registered replica output
//   launch     : drive to the replica input
//   wait_done  : last wait cycle; capt is compared in this cycle
//   fail_cnt   : saturating count of capture mismatches
module cpm_launch_cap #(
   parameter int SAMPLE_W = 8,
   parameter int CAPT_LAT = 1,
   parameter int OUT_INV  = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fire,
   input  logic                in_wait,
   input  logic                clr_fail,
   input  logic                capt,
   output logic                launch,
   output logic                wait_done,
   output logic [SAMPLE_W-1:0] fail_cnt
);

   localparam int LAT_W = $clog2(CAPT_LAT + 1);

   logic [LAT_W-1:0] lat_cnt;
   logic             exp_lvl;

   assign wait_done = in_wait && (lat_cnt == LAT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         launch   <= 1'b0;
         exp_lvl  <= 1'b0;
         lat_cnt  <= '0;
         fail_cnt <= '0;
      end else begin
         if (fire) begin
            launch  <= ~launch;
            // expected level follows the new launch value
            exp_lvl <= (~launch) ^ (OUT_INV != 0);
            lat_cnt <= LAT_W'(CAPT_LAT);
         end else if (in_wait && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
         end

         if (clr_fail) begin
            fail_cnt <= '0;
         end else if (wait_done && (capt != exp_lvl) && (fail_cnt != '1)) begin
            fail_cnt <= fail_cnt + SAMPLE_W'(1);
         end
      end
   end

endmodule

// File: rtl/cpm_sweep_ctrl.sv
// Critical-path replica sweep sequencer. Steps the path length 1..4,
// launches SAMPLES transitions per length and reports how many
// consecutive lengths passed.
//   CLK, RST       : clock, synchronous active-high reset
//   START, ABORT   : sweep request / sweep termination (ABORT wins)
//   SAMPLES        : launches per length, latched at START (0 acts as 1)
//   S              : thermometer path select to the replica
//   LAUNCH, CAPT   : replica input drive / registered replica output
//   BUSY, DONE     : sweep active / one-cycle result strobe
//   CODE, FAIL_CNT : passing length count / fails at first failing length
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | no sweep, S=0
// SETTLE    | select just changed, wait for the replica to settle
// LAUNCH    | launch pin toggled this cycle
// WAIT      | wait for capture latency, compare in last cycle
// EVAL      | decide next length or final result
// REPORT    | DONE strobe, results valid
module cpm_sweep_ctrl
   import cpm_pkg::*;
#(
   parameter int SAMPLE_W      = 8,
   parameter int SETTLE_CYCLES = 4,
   parameter int CAPT_LAT      = 1,
   parameter int OUT_INV       = 0
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                START,
   input  logic                ABORT,
   input  logic [SAMPLE_W-1:0] SAMPLES,
   output logic [3:0]          S,
   output logic                LAUNCH,
   input  logic                CAPT,
   output logic                BUSY,
   output logic                DONE,
   output logic [CODE_W-1:0]   CODE,
   output logic [SAMPLE_W-1:0] FAIL_CNT
);

   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

   cpm_state_e          state, state_n;
   logic [CODE_W-1:0]   len, len_n;
   logic [SAMPLE_W-1:0] n_q, n_start, rem;
   logic [SET_W-1:0]    set_cnt;
   logic                enter_settle, fire, in_wait, wait_done;
   logic [SAMPLE_W-1:0] fail_cnt;

   assign n_start      = (SAMPLES == '0) ? SAMPLE_W'(1) : SAMPLES;
   assign enter_settle = (state_n == ST_SETTLE) && (state != ST_SETTLE);
   assign fire         = (state_n == ST_LAUNCH);
   assign in_wait      = (state == ST_WAIT);
   assign BUSY         = (state != ST_IDLE);
   assign DONE         = (state == ST_REPORT);

   always_comb begin
      state_n = state;
      len_n   = len;
      case (state)
         ST_IDLE: begin
            if (START) begin
               state_n = ST_SETTLE;
               len_n   = CODE_W'(1);
            end
         end
         ST_SETTLE: begin
            if (set_cnt == SET_W'(1)) state_n = ST_LAUNCH;
         end
         ST_LAUNCH: state_n = ST_WAIT;
         ST_WAIT: begin
            if (wait_done) state_n = (rem == SAMPLE_W'(1)) ? ST_EVAL : ST_LAUNCH;
         end
         ST_EVAL: begin
            if ((fail_cnt == '0) && (len < CODE_W'(NUM_LEN))) begin
               len_n   = len + CODE_W'(1);
               state_n = ST_SETTLE;
            end else begin
               state_n = ST_REPORT;
            end
         end
         ST_REPORT: state_n = ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
      // also suppresses a START arriving while idle
      if (ABORT) begin
         state_n = ST_IDLE;
         len_n   = len;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         len      <= '0;
         n_q      <= '0;
         rem      <= '0;
         set_cnt  <= '0;
         S        <= 4'h0;
         CODE     <= '0;
         FAIL_CNT <= '0;
      end else begin
         state <= state_n;
         len   <= len_n;
         S     <= (state_n == ST_IDLE) ? 4'h0 : therm(len_n);

         if (enter_settle) begin
            set_cnt <= SET_W'(SETTLE_CYCLES);
            if (state == ST_IDLE) begin
               n_q <= n_start;
               rem <= n_start;
            end else begin
               rem <= n_q;
            end
         end else begin
            if (state == ST_SETTLE) set_cnt <= set_cnt - SET_W'(1);
            if (wait_done)          rem     <= rem - SAMPLE_W'(1);
         end

         if ((state == ST_EVAL) && (state_n == ST_REPORT)) begin
            CODE     <= (fail_cnt == '0) ? CODE_W'(NUM_LEN) : len - CODE_W'(1);
            FAIL_CNT <= fail_cnt;
         end
      end
   end

   cpm_launch_cap #(
      .SAMPLE_W (SAMPLE_W),
      .CAPT_LAT (CAPT_LAT),
      .OUT_INV  (OUT_INV)
   ) u_launch_cap (
      .clk       (CLK),
      .rst       (RST),
      .fire      (fire),
      .in_wait   (in_wait),
      .clr_fail  (enter_settle),
      .capt      (CAPT),
      .launch    (LAUNCH),
      .wait_done (wait_done),
      .fail_cnt  (fail_cnt)
   );

endmodule

// File: tb/tb_cpm_sweep_ctrl.sv
module tb_cpm_sweep_ctrl;

   localparam int SET_C = 4;
   localparam int LAT_C = 1;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       START = 1'b0, ABORT = 1'b0;
   logic [7:0] SAMPLES = '0;
   logic [3:0] S;
   logic       LAUNCH, BUSY, DONE;
   logic       CAPT = 1'b0;
   logic [2:0] CODE;
   logic [7:0] FAIL_CNT;

   logic       START2 = 1'b0, ABORT2 = 1'b0;
   logic [1:0] SAMPLES2 = '0;
   logic [3:0] S2;
   logic       LAUNCH2, BUSY2, DONE2;
   logic       CAPT2 = 1'b0;
   logic [2:0] CODE2;
   logic [1:0] FAIL_CNT2;

   int n_cmp = 0, n_bad = 0;
   int last_code = 0, last_fc = 0;

   always #5 CLK = ~CLK;

   cpm_sweep_ctrl #(.SAMPLE_W(8), .SETTLE_CYCLES(SET_C), .CAPT_LAT(LAT_C), .OUT_INV(0)) u_dut (
      .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .SAMPLES(SAMPLES),
      .S(S), .LAUNCH(LAUNCH), .CAPT(CAPT), .BUSY(BUSY), .DONE(DONE),
      .CODE(CODE), .FAIL_CNT(FAIL_CNT));

   cpm_sweep_ctrl #(.SAMPLE_W(2), .SETTLE_CYCLES(SET_C), .CAPT_LAT(LAT_C), .OUT_INV(1)) u_dut2 (
      .CLK(CLK), .RST(RST), .START(START2), .ABORT(ABORT2), .SAMPLES(SAMPLES2),
      .S(S2), .LAUNCH(LAUNCH2), .CAPT(CAPT2), .BUSY(BUSY2), .DONE(DONE2),
      .CODE(CODE2), .FAIL_CNT(FAIL_CNT2));

   // Replica model: registered output; at lengths >= fail_len, sample idx
   // (1-based within a length) is wrong when (idx-1) % pat == 0.
   int         fail_len = 5, pat = 1, idx = 0;
   logic [3:0] s_seen = '0;
   logic       l_seen = 1'b0;
   always @(posedge CLK) begin
      bit bad;
      if (S != s_seen) begin s_seen = S; idx = 0; end
      if (LAUNCH != l_seen) begin
         l_seen = LAUNCH;
         if (S != 4'h0) idx++;
      end
      bad = ($countones(S) >= fail_len) && (idx > 0) && (((idx - 1) % pat) == 0);
      CAPT <= LAUNCH ^ bad;
   end

   // Second replica: inverting path, every sample fails from length 2 on.
   always @(posedge CLK) CAPT2 <= ~LAUNCH2 ^ (S2 >= 4'h3);

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: per-length fail count by plain counting; sweep stops at first failure.
   function automatic void ref_sweep(input int n, input int fl, input int pt, input int w,
                                     output int code, output int fc, output int done);
      int nn, lens, f;
      nn = (n == 0) ? 1 : n;
      code = 4; fc = 0; lens = 4;
      for (int L = 1; L <= 4; L++) begin
         f = 0;
         if (L >= fl)
            for (int k = 0; k < nn; k++) if ((k % pt) == 0) f++;
         if (f > 0) begin
            code = L - 1;
            fc   = (f > (1 << w) - 1) ? (1 << w) - 1 : f;
            lens = L;
            break;
         end
      end
      done = 1 + lens * (SET_C + nn * (1 + LAT_C) + 1);
   endfunction

   task automatic run_sweep(input string name, input int n, input int fl, input int pt,
                            input int e_code, input int e_fc, input int e_done, input bit poke);
      int         cyc, toggles, lens, nn, bad_steps;
      logic [3:0] prev_s, want;
      logic       lprev;
      logic [3:0] sq[$];
      fail_len = fl; pat = pt;
      SAMPLES  = n[7:0];
      START = 1'b1; @(posedge CLK); #1; START = 1'b0;
      cyc = 1; prev_s = 4'h0; toggles = 0; lprev = LAUNCH;
      while (!DONE && cyc < 2000) begin
         if (S != prev_s) begin sq.push_back(S); prev_s = S; end
         if (LAUNCH != lprev) begin toggles++; lprev = LAUNCH; end
         if (poke) START = ($urandom_range(0, 5) == 0);
         @(posedge CLK); #1; cyc++;
      end
      START = 1'b0;
      nn   = (n == 0) ? 1 : n;
      lens = (e_code == 4) ? 4 : e_code + 1;
      chk({name, " done_cycle"}, cyc, e_done);
      chk({name, " code"}, int'(CODE), e_code);
      chk({name, " fail_cnt"}, int'(FAIL_CNT), e_fc);
      chk({name, " launches"}, toggles, lens * nn);
      chk({name, " s_steps"}, sq.size(), lens);
      bad_steps = 0;
      foreach (sq[i]) begin
         want = 4'((1 << (i + 1)) - 1);
         if (sq[i] != want) bad_steps++;
      end
      chk({name, " s_seq_bad"}, bad_steps, 0);
      // START in the DONE cycle must be ignored
      START = 1'b1; @(posedge CLK); #1; START = 1'b0;
      chk({name, " busy_after_done"}, int'(BUSY), 0);
      chk({name, " s_after_done"}, int'(S), 0);
      last_code = e_code; last_fc = e_fc;
   endtask

   typedef struct {
      string name;
      int    n, fl, pt;
      int    code, fc, done;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int code, fc, done, found, dcount, n, fl, pt, cyc;
      logic lprev;

      vecs[0] = '{"all_pass_16",  16, 5, 1, 4, 0, 149};
      vecs[1] = '{"all_pass_4",    4, 5, 1, 4, 0,  53};
      vecs[2] = '{"fail_len3",     8, 3, 1, 2, 8,  64};
      vecs[3] = '{"intermit_s0",   0, 1, 4, 0, 1,   8};
      vecs[4] = '{"half_fail_l2",  5, 2, 2, 1, 3,  31};

      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      chk("rst S", int'(S), 0);
      chk("rst LAUNCH", int'(LAUNCH), 0);
      chk("rst BUSY", int'(BUSY), 0);
      chk("rst DONE", int'(DONE), 0);
      chk("rst CODE", int'(CODE), 0);
      chk("rst FAIL_CNT", int'(FAIL_CNT), 0);

      foreach (vecs[i])
         run_sweep(vecs[i].name, vecs[i].n, vecs[i].fl, vecs[i].pt,
                   vecs[i].code, vecs[i].fc, vecs[i].done, 1'b1);

      // ABORT in WAIT of length 2
      fail_len = 5; pat = 1; SAMPLES = 8'd4;
      START = 1'b1; @(posedge CLK); #1; START = 1'b0;
      found = 0; lprev = LAUNCH;
      for (int c = 0; c < 200 && found == 0; c++) begin
         if (S == 4'h3 && LAUNCH != lprev) found = 1;
         else begin lprev = LAUNCH; @(posedge CLK); #1; end
      end
      chk("abort reach_len2_launch", found, 1);
      @(posedge CLK); #1;
      ABORT = 1'b1; @(posedge CLK); #1; ABORT = 1'b0;
      chk("abort BUSY", int'(BUSY), 0);
      chk("abort S", int'(S), 0);
      chk("abort DONE", int'(DONE), 0);
      chk("abort CODE kept", int'(CODE), last_code);
      chk("abort FAIL_CNT kept", int'(FAIL_CNT), last_fc);
      dcount = 0;
      repeat (10) begin @(posedge CLK); #1; if (DONE) dcount++; end
      chk("abort no_done", dcount, 0);
      run_sweep("after_abort", 3, 4, 1, 3, 3, 1 + 4 * (SET_C + 3 * 2 + 1), 1'b0);

      // ABORT and START together while idle
      ABORT = 1'b1; START = 1'b1; @(posedge CLK); #1; ABORT = 1'b0; START = 1'b0;
      chk("idle abort+start BUSY", int'(BUSY), 0);

      // RST during SETTLE
      fail_len = 5; SAMPLES = 8'd2;
      START = 1'b1; @(posedge CLK); #1; START = 1'b0;
      @(posedge CLK); #1;
      chk("pre_rst S", int'(S), 1);
      RST = 1'b1; @(posedge CLK); #1; RST = 1'b0;
      chk("mid_rst S", int'(S), 0);
      chk("mid_rst BUSY", int'(BUSY), 0);
      chk("mid_rst DONE", int'(DONE), 0);
      chk("mid_rst CODE", int'(CODE), 0);
      chk("mid_rst FAIL_CNT", int'(FAIL_CNT), 0);
      chk("mid_rst LAUNCH", int'(LAUNCH), 0);
      run_sweep("post_rst", 2, 5, 1, 4, 0, 37, 1'b0);

      // Randomized sweeps against the reference
      for (int r = 0; r < 16; r++) begin
         n  = $urandom_range(0, 12);
         fl = $urandom_range(1, 5);
         pt = $urandom_range(1, 4);
         ref_sweep(n, fl, pt, 8, code, fc, done);
         run_sweep($sformatf("rand%0d", r), n, fl, pt, code, fc, done, 1'b1);
      end

      // Narrow counter instance, inverting replica, fails from length 2
      for (int j = 0; j < 2; j++) begin
         SAMPLES2 = (j == 0) ? 2'd3 : 2'd0;
         START2 = 1'b1; @(posedge CLK); #1; START2 = 1'b0;
         cyc = 1;
         while (!DONE2 && cyc < 500) begin @(posedge CLK); #1; cyc++; end
         chk($sformatf("w2 run%0d done_cycle", j), cyc, (j == 0) ? 23 : 15);
         chk($sformatf("w2 run%0d code", j), int'(CODE2), 1);
         chk($sformatf("w2 run%0d fail_cnt", j), int'(FAIL_CNT2), (j == 0) ? 3 : 1);
         @(posedge CLK); #1;
         chk($sformatf("w2 run%0d busy_after", j), int'(BUSY2), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
